load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 18 +
 rtl/load_align.sv | 25 ++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states, byte-enable patterns.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;
endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the addressed byte/half out of the bus word and extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    assign byte_sh = rdata >> {offset, 3'b000};
    assign half_sh = rdata >> {offset[1], 4'b0000};

    always_comb begin
        case (funct3)
            F3_B:    result = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_BU:   result = {24'd0, byte_sh[7:0]};
            F3_H:    result = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_HU:   result = {16'd0, half_sh[15:0]};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: issues one bus access per load/store and stalls the core until it completes.
// Optional LSU_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES cycles without bus_ready_i.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] address_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ready_i,
    input  logic [31:0] bus_rdata_i
);
    lsu_state_e  state, state_next;
    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  offset_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;

    logic        is_half, is_word, misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] align_data;
    logic        issue, capture, abort, expired;

    // Size is decoded from funct3[1:0] for both loads and stores, so 011/11x fall to word.
    assign is_half    = (funct3_i[1:0] == 2'b01);
    assign is_word    = funct3_i[1];
    assign misaligned = (is_half & address_i[0]) | (is_word & (|address_i[1:0]));

    always_comb begin
        be_calc    = 4'b0001 << address_i[1:0];
        wdata_calc = {4{store_data_i[7:0]}};
        if (is_word) begin
            be_calc    = BE_WORD;
            wdata_calc = store_data_i;
        end else if (is_half) begin
            be_calc    = address_i[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_calc = {2{store_data_i[15:0]}};
        end
    end

    load_align u_align (
        .rdata  (bus_rdata_i),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (align_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt;
    logic          err_q;

    assign expired     = (tcnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus_error_o = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
            if (state != ACCESS)
                tcnt <= '0;
            else if (tcnt != CW'(TIMEOUT_CYCLES))
                tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign expired     = 1'b0;
    assign bus_error_o = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        bus_req_o    = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_o   = '0;
        bus_be_o     = '0;
        bus_wdata_o  = '0;
        issue        = 1'b0;
        capture      = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read_i | mem_write_i) begin
                    if (misaligned) begin
                        misaligned_o = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        issue      = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall_o     = 1'b1;
                bus_req_o   = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = addr_q;
                bus_be_o    = be_q;
                bus_wdata_o = wdata_q;
                // A ready coinciding with expiry completes normally.
                if (bus_ready_i) begin
                    capture    = ~we_q;
                    state_next = DONE;
                end else if (expired) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            offset_q    <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            load_data_o <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                we_q     <= mem_write_i;
                addr_q   <= {address_i[31:2], 2'b00};
                offset_q <= address_i[1:0];
                be_q     <= be_calc;
                wdata_q  <= mem_write_i ? wdata_calc : 32'd0;
                funct3_q <= funct3_i;
            end
            if (capture)
                load_data_o <= align_data;
            else if (abort)
                load_data_o <= '0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of accesses plus reset-abort and timeout sequences.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] address_i, store_data_i;
    logic [31:0] load_data_o;
    logic        stall_o, misaligned_o, bus_error_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ready_i;
    logic [31:0] bus_rdata_i;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .address_i    (address_i),
        .store_data_i (store_data_i),
        .load_data_o  (load_data_o),
        .stall_o      (stall_o),
        .misaligned_o (misaligned_o),
        .bus_error_o  (bus_error_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ready_i  (bus_ready_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
    } vec_t;

    vec_t vecs[16];
    int   applied = 0;
    int   errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        funct3_i     = 3'b000;
        address_i    = 32'd0;
        store_data_i = 32'd0;
        bus_ready_i  = 1'b0;
        bus_rdata_i  = 32'd0;
    endtask

    // Entered and left just after a rising edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        int stalls;
        mem_read_i   = v.rd;
        mem_write_i  = v.wr;
        funct3_i     = v.f3;
        address_i    = v.addr;
        store_data_i = v.sdata;
        @(negedge clk);
        chk("issue_misaligned", 32'(misaligned_o), 32'(v.mis));
        chk("issue_stall", 32'(stall_o), 32'(!v.mis));
        chk("issue_req", 32'(bus_req_o), 32'd0);
        @(posedge clk); #1;
        if (v.mis) begin
            idle_inputs();
            @(negedge clk);
            chk("mis_req", 32'(bus_req_o), 32'd0);
            chk("mis_stall", 32'(stall_o), 32'd0);
            chk("mis_load", load_data_o, v.load);
            @(posedge clk); #1;
            return;
        end
        stalls = 1;
        for (int i = 0; i <= v.waits; i++) begin
            // Junk on the request side must not disturb the access in flight.
            mem_read_i   = 1'b1;
            mem_write_i  = 1'($urandom_range(0, 1));
            funct3_i     = 3'($urandom);
            address_i    = $urandom;
            store_data_i = $urandom;
            bus_ready_i  = (i == v.waits);
            bus_rdata_i  = (i == v.waits) ? v.rdata : $urandom;
            @(negedge clk);
            if (stall_o) stalls++;
            chk("acc_req", 32'(bus_req_o), 32'd1);
            chk("acc_we", 32'(bus_we_o), 32'(v.wr));
            chk("acc_be", 32'(bus_be_o), 32'(v.be));
            chk("acc_addr", bus_addr_o, {v.addr[31:2], 2'b00});
            chk("acc_wdata", bus_wdata_o, v.wdata);
            @(posedge clk); #1;
        end
        bus_ready_i = 1'b0;
        bus_rdata_i = $urandom;
        @(negedge clk);
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_req", 32'(bus_req_o), 32'd0);
        chk("done_error", 32'(bus_error_o), 32'd0);
        chk("done_load", load_data_o, v.load);
        chk("stall_cycles", 32'(stalls), 32'(v.waits + 2));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        //            rd    wr    f3      addr          sdata         rdata      waits mis  be       wdata          load
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0,        32'h1280FF34, 3, 1'b0, 4'b0100, 32'h0,        32'hFFFFFF80};
        vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h1280FF34, 0, 1'b0, 4'b0100, 32'h0,        32'h00000080};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h106, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h00000080};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h1280FF34, 1, 1'b0, 4'b1100, 32'h0,        32'h00001280};
        vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h7FFF8001, 0, 1'b0, 4'b0011, 32'h0,        32'hFFFF8001};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h108, 32'h0,        32'hCAFEF00D, 1, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h10A, 32'h1234ABCD, 32'h0,        2, 1'b0, 4'b1100, 32'hABCDABCD, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h7F000000, 0, 1'b0, 4'b1000, 32'h0,        32'h0000007F};
        vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0000007F};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h10C, 32'h0,        32'h11223344, 0, 1'b0, 4'b1111, 32'h0,        32'h11223344};
        vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h110, 32'h00000055, 32'h99999999, 1, 1'b0, 4'b1111, 32'h00000055, 32'h11223344};
        vecs[13] = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'hFFFE0000, 0, 1'b0, 4'b1100, 32'h0,        32'h0000FFFE};
        vecs[14] = '{1'b0, 1'b1, 3'b011, 32'h114, 32'h89ABCDEF, 32'h0,        0, 1'b0, 4'b1111, 32'h89ABCDEF, 32'h0000FFFE};
        vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0000FFFE};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_load", load_data_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_error", 32'(bus_error_o), 32'd0);
        chk("rst_mis", 32'(misaligned_o), 32'd0);
        chk("rst_bus", {bus_we_o, bus_be_o, bus_addr_o[26:0]}, 32'd0);
        chk("rst_wdata", bus_wdata_o, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Reset on the second ACCESS cycle of an LH cancels it; a late ready is ignored.
        mem_read_i = 1'b1;
        funct3_i   = 3'b001;
        address_i  = 32'h102;
        @(negedge clk);
        chk("rs_issue_stall", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rs_acc1_req", 32'(bus_req_o), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rs_acc2_req", 32'(bus_req_o), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rs_after_req", 32'(bus_req_o), 32'd0);
        chk("rs_after_stall", 32'(stall_o), 32'd0);
        chk("rs_after_load", load_data_o, 32'd0);
        @(posedge clk); #1;
        bus_ready_i = 1'b1;
        bus_rdata_i = 32'h1280FF34;
        @(negedge clk);
        chk("rs_late_req", 32'(bus_req_o), 32'd0);
        chk("rs_late_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rs_late_load", load_data_o, 32'd0);
        chk("rs_late_stall2", 32'(stall_o), 32'd0);
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        begin
            int reqs;
            run_vec(vecs[11]);
            mem_read_i = 1'b1;
            funct3_i   = 3'b010;
            address_i  = 32'h100;
            @(posedge clk); #1;
            idle_inputs();
            reqs = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!bus_req_o) break;
                reqs++;
                @(posedge clk); #1;
            end
            chk("to_req_cycles", 32'(reqs), 32'd16);
            chk("to_error", 32'(bus_error_o), 32'd1);
            chk("to_load", load_data_o, 32'd0);
            chk("to_stall", 32'(stall_o), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("to_error_clear", 32'(bus_error_o), 32'd0);
            chk("to_idle_req", 32'(bus_req_o), 32'd0);
            @(posedge clk); #1;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule
